digital_clock: RTL and testbench
================================

DIGITAL_CLOCK -- requirements
Module: digital_clock

Interface
REQ-001 Parameter: SEC_MOD, default 60, seconds modulus.
REQ-002 Parameter: MIN_MOD, default 60, minutes modulus.
REQ-003 Parameter: HOUR_MOD, default 24, hours modulus; range 2..32.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Port: Clk_1sec  input  1  clock, one rising edge per second, sole clock.
REQ-006 Port: reset  input  1  asynchronous active-high reset.
REQ-007 Port: seconds  output  6  current seconds, 0..SEC_MOD-1, binary.
REQ-008 Port: minutes  output  6  current minutes, 0..MIN_MOD-1, binary.
REQ-009 Port: hours  output  5  current hours, 0..HOUR_MOD-1, binary.

Function
REQ-010 All outputs SHALL be driven directly from registers clocked on the rising edge of Clk_1sec, with no combinational path from inputs.
REQ-011 seconds SHALL increment by 1 on every rising edge of Clk_1sec while reset is low.
REQ-012 When seconds = SEC_MOD-1, the next edge SHALL set seconds to 0 and raise a seconds carry in the same cycle.
REQ-013 minutes SHALL increment by 1 only on an edge where the seconds carry is asserted (seconds = 59).
REQ-014 When minutes = MIN_MOD-1 and the seconds carry is asserted, the next edge SHALL set minutes to 0 and raise a minutes carry.
REQ-015 hours SHALL increment by 1 only on an edge where the minutes carry is asserted (minutes = 59 and seconds = 59).
REQ-016 When hours = HOUR_MOD-1 and the minutes carry is asserted, the next edge SHALL set hours to 0.
  - At 23:59:59 the next edge SHALL give 00:00:00 in a single cycle.
REQ-017 Carries SHALL ripple combinationally within one edge.
  - Every output update SHALL have zero-cycle latency.
  - There SHALL be no intermediate states such as 00:60.
REQ-018 No counter SHALL ever reach or exceed its modulus.
  - Defensive rule: if a register holds a value ≥ its modulus, the next enabled edge SHALL load 0.
REQ-019 The full period SHALL be SEC_MOD*MIN_MOD*HOUR_MOD edges (86400 at default parameters).

Reset
REQ-020 When reset is asserted, seconds, minutes and hours SHALL go to 0 immediately, without waiting for a clock edge.
REQ-021 Outputs SHALL stay at 0 while reset is high, regardless of Clk_1sec activity.
REQ-022 The first rising edge after reset deasserts SHALL give seconds = 1.
REQ-023 Reset asserted mid-count (including on a wrap edge) SHALL override any increment or carry.
REQ-024 There SHALL be no power-up state other than the reset state; reset SHALL be applied before use.

Structure
REQ-025 A shared package digital_clock_pkg SHALL hold the default moduli constants (60, 60, 24) and the output widths (6, 6, 5).
REQ-026 One sub-module, mod_n_counter, SHALL be used.
  - Parameters: N and width.
  - Inputs: clk, async reset, enable.
  - Outputs: count, carry_out = enable AND count = N-1.
REQ-027 digital_clock SHALL instantiate mod_n_counter three times, chained seconds → minutes → hours through their carry outputs.
  - The seconds instance enable SHALL be tied to 1.

Verification
REQ-028 Reset high for 100 ns, then release, then 1 edge -> 00:00:01; after 59 edges total -> 00:00:59.
REQ-029 From reset, 60 edges -> seconds = 0, minutes = 1, hours = 0; 3600 edges -> 01:00:00.
REQ-030 From reset, 86399 edges -> 23:59:59; the next edge -> 00:00:00 with all three counters wrapping together.
REQ-031 From 12:34:56, assert reset between clock edges -> all outputs 0 before the next edge; hold reset over 5 edges -> stays 00:00:00.
REQ-032 Reset asserted coincident with the edge at 00:59:59 -> 00:00:00, never 01:00:00.
REQ-033 Scoreboard over a 90000-edge run compares against a reference model (edge count mod 86400 split into h:m:s) and asserts on every edge that seconds < 60, minutes < 60 and hours < 24.

Source files
------------

// File: rtl/digital_clock_pkg.sv
// Shared constants for the digital clock: default moduli and output widths.
package digital_clock_pkg;

  localparam int SEC_MOD_DEF  = 60;
  localparam int MIN_MOD_DEF  = 60;
  localparam int HOUR_MOD_DEF = 24;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

endpackage : digital_clock_pkg

// File: rtl/digital_clock_mod_n_counter.sv
// Modulo-N up-counter with enable and a combinational terminal-count carry.
// A count at or above N-1 returns to 0 on the next enabled edge. This also
// recovers from any out-of-range value.
module mod_n_counter
  import digital_clock_pkg::*;
#(
  parameter int N     = SEC_MOD_DEF,
  parameter int WIDTH = SEC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             carry_out
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next-count logic: hold, increment, or wrap to zero at/after the last value.
  always_comb begin
    count_d = count_q;
    if (en) begin
      if (count_q >= LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // Count register; reset clears it immediately, independent of the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign carry_out = en && (count_q == LAST);

endmodule : mod_n_counter

// File: rtl/digital_clock.sv
// 24-hour digital clock: seconds -> minutes -> hours counters chained by
// carries. Every output comes straight from a counter register.
module digital_clock
  import digital_clock_pkg::*;
#(
  parameter int SEC_MOD  = SEC_MOD_DEF,
  parameter int MIN_MOD  = MIN_MOD_DEF,
  parameter int HOUR_MOD = HOUR_MOD_DEF
) (
  input  logic              Clk_1sec,
  input  logic              reset,
  output logic [SEC_W-1:0]  seconds,
  output logic [MIN_W-1:0]  minutes,
  output logic [HOUR_W-1:0] hours
);

  logic sec_carry;
  logic min_carry;

  // Seconds advance on every edge.
  mod_n_counter #(
    .N     (SEC_MOD),
    .WIDTH (SEC_W)
  ) u_sec (
    .clk       (Clk_1sec),
    .rst       (reset),
    .en        (1'b1),
    .count     (seconds),
    .carry_out (sec_carry)
  );

  // Minutes advance on the edge that wraps seconds.
  mod_n_counter #(
    .N     (MIN_MOD),
    .WIDTH (MIN_W)
  ) u_min (
    .clk       (Clk_1sec),
    .rst       (reset),
    .en        (sec_carry),
    .count     (minutes),
    .carry_out (min_carry)
  );

  // Hours advance on the edge that wraps minutes. The day-wrap carry has no consumer.
  mod_n_counter #(
    .N     (HOUR_MOD),
    .WIDTH (HOUR_W)
  ) u_hour (
    .clk       (Clk_1sec),
    .rst       (reset),
    .en        (min_carry),
    .count     (hours),
    .carry_out ()
  );

endmodule : digital_clock

// File: tb/tb_digital_clock.sv
// Directed bench for digital_clock: long counting run with a time-of-day
// reference and named checkpoints, then coincident and asynchronous resets.
module tb_digital_clock;

  logic       clk;
  logic       reset;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;

  int n_cmp;
  int n_bad;

  digital_clock dut (
    .Clk_1sec (clk),
    .reset    (reset),
    .seconds  (seconds),
    .minutes  (minutes),
    .hours    (hours)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_hms(input string tag, input int h, input int m, input int s);
    check_val({tag, "_h"}, int'(hours),   h);
    check_val({tag, "_m"}, int'(minutes), m);
    check_val({tag, "_s"}, int'(seconds), s);
  endtask

  initial begin
    int c;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    #1 reset = 1'b1;

    // Reset held for 100 ns with the clock running.
    #49 check_hms("rst_hold", 0, 0, 0);
    #50;
    @(negedge clk);
    check_hms("rst_state", 0, 0, 0);
    reset = 1'b0;

    // 90000-edge run against edge-count reference.
    for (int e = 1; e <= 89999; e++) begin
      @(negedge clk);
      c = e % 86400;
      check_val("hms_ref", {hours, minutes, seconds},
                {5'(c / 3600), 6'((c / 60) % 60), 6'(c % 60)});
      check_val("range", ((seconds < 60) && (minutes < 60) && (hours < 24)) ? 1 : 0, 1);
      case (e)
        1:     check_hms("first_edge", 0, 0, 1);
        59:    check_hms("edge59", 0, 0, 59);
        60:    check_hms("min_carry", 0, 1, 0);
        3600:  check_hms("hour_carry", 1, 0, 0);
        45296: check_hms("midday", 12, 34, 56);
        86399: check_hms("day_end", 23, 59, 59);
        86400: check_hms("day_wrap", 0, 0, 0);
        89999: check_hms("pre_coinc", 0, 59, 59);
        default: ;
      endcase
    end

    // Reset coincident with the edge that would give 01:00:00.
    @(posedge clk);
    reset = 1'b1;
    #1 check_hms("coinc_rst", 0, 0, 0);
    @(negedge clk);
    check_hms("coinc_hold", 0, 0, 0);
    reset = 1'b0;

    // Count up a little, then reset asynchronously between edges.
    repeat (10) @(negedge clk);
    check_hms("pre_async", 0, 0, 10);
    #2 reset = 1'b1;
    #1 check_hms("async_rst", 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_hms("rst_5edges", 0, 0, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check_hms("post_release", 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_digital_clock
